// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg
// Shared types and constants for the GPU frame-memory port-A arbiter.
//   arb_state_t   : arbiter FSM state encoding (also exported for debug)
//   GPU_ADDR_W    : word address width of the GPU frame memory
//   GPU_DATA_W    : data word width
//   GPU_BURST_LEN : default number of words per display burst
package gpu_mem_pkg;

    localparam int GPU_ADDR_W    = 14;
    localparam int GPU_DATA_W    = 32;
    localparam int GPU_BURST_LEN = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CPU_ISSUE = 3'd1,
        ST_CPU_DONE  = 3'd2,
        ST_BURST     = 3'd3,
        ST_DRAIN     = 3'd4
    } arb_state_t;

    // Counter width needed to index BURST_LEN words (at least one bit).
    function automatic int burst_cnt_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/gpu_mem_arbiter_if.sv
// gpu_mem_arbiter_if
// Bundles the three buses around the port-A arbiter:
//   CPU bridge  : cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_ack/cpu_rdata out
//   Display     : disp_req/disp_addr in, disp_ack/disp_valid/disp_data/disp_last out
//   Memory      : mem_address/mem_data/mem_wren out, mem_q in (1-cycle latency)
// Handshake semantics: a requester raises *_req and holds it (with its
// address/data stable) until it sees the matching one-cycle *_ack pulse; the
// arbiter never acks a request it has not sampled, and a request still high
// in the ack cycle is not taken as a new request.
// Modports: slave = arbiter side, master = requesters + memory side.
interface gpu_mem_arbiter_if
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_W = GPU_ADDR_W,
    parameter int DATA_W = GPU_DATA_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_ack;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;
    logic              disp_last;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  disp_req, disp_addr,
        output disp_ack, disp_valid, disp_data, disp_last,
        output mem_address, mem_data, mem_wren,
        input  mem_q
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output disp_req, disp_addr,
        input  disp_ack, disp_valid, disp_data, disp_last,
        input  mem_address, mem_data, mem_wren,
        output mem_q
    );

endinterface

// File: rtl/gpu_burst_counter.sv
// gpu_burst_counter
// Address generator for display bursts.
//   clock, aclr : rising-edge clock, asynchronous active-high reset
//   load        : latch base_in as burst base and restart the word counter
//   base_in     : burst base address
//   advance     : one word issued this cycle, step the counter
//   address     : base + counter, wrapping modulo 2^ADDR_W
//   last        : the word being issued now is the final word of the burst
module gpu_burst_counter
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_W    = GPU_ADDR_W,
    parameter int BURST_LEN = GPU_BURST_LEN
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_in,
    input  logic              advance,
    output logic [ADDR_W-1:0] address,
    output logic              last
);

    localparam int CW = burst_cnt_w(BURST_LEN);

    logic [ADDR_W-1:0] base;
    logic [CW-1:0]     count;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            base  <= '0;
            count <= '0;
        end else if (load) begin
            base  <= base_in;
            count <= '0;
        end else if (advance) begin
            count <= count + 1'b1;
        end
    end

    // Plain modular add: crossing the top of memory wraps silently to 0.
    assign address = base + ADDR_W'(count);
    assign last    = (count == CW'(BURST_LEN - 1));

endmodule

// File: rtl/gpu_mem_arbiter.sv
// gpu_mem_arbiter
// Shares port A of the GPU frame memory between the CPU bus bridge
// (single-word read/write) and the display scanout fetcher (read bursts of
// BURST_LEN words).
//   clock, aclr : rising-edge clock, asynchronous active-high reset
//   bus         : slave view of gpu_mem_arbiter_if (CPU, display, memory)
//   dbg_state   : current FSM state, for observation only
module gpu_mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_W    = GPU_ADDR_W,
    parameter int DATA_W    = GPU_DATA_W,
    parameter int BURST_LEN = GPU_BURST_LEN
) (
    input  logic                clock,
    input  logic                aclr,
    gpu_mem_arbiter_if.slave    bus,
    output arb_state_t          dbg_state
);

    arb_state_t        state;
    logic              cpu_owed;
    logic [ADDR_W-1:0] cpu_addr_q;
    logic              cpu_we_q;
    logic [DATA_W-1:0] cpu_wdata_q;
    logic              cpu_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              disp_ack_q;
    logic              disp_valid_q;
    logic              disp_last_q;

    logic              cpu_req_eff;
    logic              grant_cpu;
    logic              grant_disp;
    logic              in_burst;
    logic [ADDR_W-1:0] burst_addr;
    logic              burst_last;

    logic [ADDR_W-1:0] mem_address_c;
    logic [DATA_W-1:0] mem_data_c;
    logic              mem_wren_c;

    // A request still high in its own ack cycle is the old request.
    assign cpu_req_eff = bus.cpu_req & ~cpu_ack_q;
    assign in_burst    = (state == ST_BURST);

    // Owed CPU first, then display, then CPU: the CPU waits at most one
    // burst and the display waits at most one CPU access.
    always_comb begin
        grant_cpu  = 1'b0;
        grant_disp = 1'b0;
        if (state == ST_IDLE) begin
            if (cpu_owed && cpu_req_eff) begin
                grant_cpu = 1'b1;
            end else if (bus.disp_req) begin
                grant_disp = 1'b1;
            end else if (cpu_req_eff) begin
                grant_cpu = 1'b1;
            end
        end
    end

    gpu_burst_counter #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN)
    ) u_burst_counter (
        .clock   (clock),
        .aclr    (aclr),
        .load    (grant_disp),
        .base_in (bus.disp_addr),
        .advance (in_burst),
        .address (burst_addr),
        .last    (burst_last)
    );

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state        <= ST_IDLE;
            cpu_owed     <= 1'b0;
            cpu_addr_q   <= '0;
            cpu_we_q     <= 1'b0;
            cpu_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            disp_ack_q   <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_last_q  <= 1'b0;
        end else begin
            cpu_ack_q    <= 1'b0;
            disp_ack_q   <= 1'b0;
            // Read data returns one cycle after its address was issued.
            disp_valid_q <= in_burst;
            disp_last_q  <= in_burst && burst_last;
            if ((state == ST_BURST || state == ST_DRAIN) && bus.cpu_req) begin
                cpu_owed <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (grant_cpu) begin
                        cpu_addr_q  <= bus.cpu_addr;
                        cpu_we_q    <= bus.cpu_we;
                        cpu_wdata_q <= bus.cpu_wdata;
                        cpu_owed    <= 1'b0;
                        state       <= ST_CPU_ISSUE;
                    end else if (grant_disp) begin
                        disp_ack_q <= 1'b1;
                        state      <= ST_BURST;
                    end
                end
                ST_CPU_ISSUE: state <= ST_CPU_DONE;
                ST_CPU_DONE: begin
                    if (!cpu_we_q) begin
                        cpu_rdata_q <= bus.mem_q;
                    end
                    cpu_ack_q <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_BURST: begin
                    if (burst_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Memory side is a pure decode of registered state, so reset clears
    // mem_wren immediately and aborts an in-flight write.
    always_comb begin
        mem_address_c = '0;
        mem_data_c    = '0;
        mem_wren_c    = 1'b0;
        case (state)
            ST_CPU_ISSUE: begin
                mem_address_c = cpu_addr_q;
                mem_data_c    = cpu_wdata_q;
                mem_wren_c    = cpu_we_q;
            end
            ST_BURST: mem_address_c = burst_addr;
            default: ;
        endcase
    end

    assign bus.mem_address = mem_address_c;
    assign bus.mem_data    = mem_data_c;
    assign bus.mem_wren    = mem_wren_c;

    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.disp_ack   = disp_ack_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_data  = disp_valid_q ? bus.mem_q : '0;
    assign bus.disp_last  = disp_last_q;

    assign dbg_state = state;

endmodule

// File: doc/gpu_mem_arbiter.md
# gpu_mem_arbiter

Single-port arbiter that shares port A of the GPU frame memory between two requesters: the CPU bus bridge (single-word read/write, req/ack) and the display scanout fetcher (fixed-length read bursts). Sits between those requesters and the GPU memory wrapper. It drives the memory's address, data and write-enable directly and consumes its one-cycle-latency read data. Port B is not touched.

## Interface
- ADDR_W, 14, word address width (matches GPU memory depth)
- DATA_W, 32, data word width
- BURST_LEN, 16, words per display burst (power of two, 2..256)

- clock  in  1  system clock; all logic rising-edge
- aclr  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; latched with request
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack, held until next ack
- disp_req  in  1  burst request, held until disp_ack
- disp_addr  in  ADDR_W  burst base address
- disp_ack  out  1  one-cycle burst-accepted pulse
- disp_valid  out  1  disp_data valid this cycle
- disp_data  out  DATA_W  burst word; 0 when disp_valid=0
- disp_last  out  1  marks final burst word (coincident with disp_valid)
- mem_address  out  ADDR_W  to memory address_a
- mem_data  out  DATA_W  to memory data_a
- mem_wren  out  1  to memory wren_a
- mem_q  in  DATA_W  from memory q_a; valid one cycle after address

## Operation
- FSM states: IDLE, CPU_ISSUE, CPU_DONE, BURST, DRAIN.
- IDLE: no memory access (mem_wren=0). Grant rules, evaluated each IDLE cycle:
  - cpu_owed && cpu_req → CPU
  - else disp_req → display
  - else cpu_req → CPU
  - cpu_req is ignored in any cycle where cpu_ack=1, which prevents a double access.
- CPU grant: latch cpu_addr/we/wdata, clear cpu_owed, go CPU_ISSUE.
- CPU_ISSUE: mem_address=latched addr, mem_data=latched wdata, mem_wren=latched we; go CPU_DONE.
- CPU_DONE: at end of cycle load cpu_rdata←mem_q (reads only; writes leave cpu_rdata unchanged) and set cpu_ack for one cycle; go IDLE.
- Display grant: latch base, counter←0, disp_ack=1 next cycle; go BURST.
- BURST: mem_address=(base+counter) mod 2^ADDR_W, mem_wren=0, counter++. After issuing word BURST_LEN-1 go DRAIN.
- DRAIN: no new address; last word returns; go IDLE.
- disp_valid is a one-cycle-delayed copy of "BURST issued"; disp_data=mem_q gated by disp_valid; disp_last is the delayed copy of the final issue.
- cpu_owed: set in any BURST/DRAIN cycle with cpu_req=1. This bounds CPU wait to one burst; display is never starved beyond one CPU access.
- mem_address/mem_data are 0 in IDLE, DRAIN and CPU_DONE.

## Timing
- Reset (aclr=1, asynchronous): state=IDLE, counter=0, cpu_owed=0, every output 0. mem_wren drops immediately, so an in-flight write is aborted. A burst in progress is dropped with no further disp_valid.
- CPU: request sampled in IDLE at cycle T → issue T+1 → capture T+2 → cpu_ack and cpu_rdata visible T+3, state IDLE at T+3. Reads and writes have identical latency.
- Display: request sampled at T → disp_ack at T+1. Addresses issued T+1..T+BURST_LEN. disp_valid T+2..T+BURST_LEN+1, disp_last at T+BURST_LEN+1, IDLE at T+BURST_LEN+2.
- Back-to-back grants have no dead cycle beyond the states above. Throughput is one word/cycle inside a burst.
- Address wrap-around 0x3FFF→0x0000 within a burst is legal and silent.

## Structure
- Package gpu_mem_pkg: state enum, GPU_ADDR_W=14, GPU_DATA_W=32, default burst length constant.
- One sub-module, gpu_burst_counter: base latch, counter, wrap add, last-issue flag.
- Top instantiates gpu_burst_counter; FSM, fairness flag and CPU latch live in gpu_mem_arbiter.

## Test plan
- CPU write 0xDEADBEEF to 0x0123, then read 0x0123: mem_wren high exactly one cycle; each ack at T+3; cpu_rdata=0xDEADBEEF.
- Preload word n = n; display burst at 0x0100: disp_ack at T+1; 16 consecutive valid words 0x100..0x10F; disp_last only on 0x10F.
- Burst at 0x3FF8: data from 0x3FF8..0x3FFF then 0x0000..0x0007, no gap.
- cpu_req and disp_req rise in the same IDLE cycle T, with disp_req re-asserted after its burst: burst runs first; CPU access wins next, ack at T+21; second burst starts only after that.
- cpu_req held high through and after ack: exactly one mem access per request.
- aclr pulsed at burst cycle 5: all outputs 0 that cycle, no further disp_valid. After release, a CPU read of 0x0002 returns its preloaded value at T+3.
